// File: rtl/dcache_plru_controller.sv
// -----------------------------------------------------------------------------
// dcache_plru_controller
//
// Read-modify-write owner of the Dcache PLRU tree buffer (32 sets x 7 tree
// bits, 8 ways). Each accepted request reads the set's tree, selects a victim
// (ALLOC) and writes back the touched tree. Only one request is in flight, so
// the next read always observes the previous write.
//
// Ports:
//   fire                  clock, all state updates on rising edge
//   rstn                  asynchronous active-low reset
//   i_req_valid/o_req_ready      request handshake (ready only in IDLE)
//   i_req_op              0 = TOUCH, 1 = ALLOC
//   i_req_set_5           set index
//   i_req_way_3           hit way (TOUCH)
//   i_valid_mask_8        per-way valid bits (ALLOC), 1 = valid
//   o_resp_valid/i_resp_ready    response handshake
//   o_victim_way_3        chosen way for ALLOC, 0 for TOUCH
//   o_plru_buffer_addr_5  buffer address (captured set, held in IDLE)
//   o_plru_write_enable   one-cycle buffer write strobe
//   o_data_out_7          tree value to write
//   i_data_in_7           buffer read data, combinational from address
//
// Tree encoding: b0 root, b1/b2 left/right nodes, b3..b6 leaf pairs
// {0,1},{2,3},{4,5},{6,7}; a 0 bit points toward the lower ways.
// -----------------------------------------------------------------------------
module dcache_plru_controller (
   input  logic       fire,
   input  logic       rstn,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_req_op,
   input  logic [4:0] i_req_set_5,
   input  logic [2:0] i_req_way_3,
   input  logic [7:0] i_valid_mask_8,
   output logic       o_resp_valid,
   input  logic       i_resp_ready,
   output logic [2:0] o_victim_way_3,
   output logic [4:0] o_plru_buffer_addr_5,
   output logic       o_plru_write_enable,
   output logic [6:0] o_data_out_7,
   input  logic [6:0] i_data_in_7
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t     r_state;
   logic       r_op;
   logic [4:0] r_set;
   logic [2:0] r_way;
   logic [7:0] r_mask;
   logic       r_req_ready;
   logic       r_resp_valid;
   logic       r_write_enable;
   logic [2:0] r_victim;
   logic [6:0] r_data_out;

   logic [2:0] w_victim;
   logic [6:0] w_new_tree;

   // Follow the tree pointers from the root down to the pseudo-LRU way.
   function automatic logic [2:0] plru_walk(input logic [6:0] tree);
      logic [2:0] v;
      logic [2:0] leaf_idx;
      v[2]     = tree[0];
      v[1]     = v[2] ? tree[2] : tree[1];
      leaf_idx = 3'd3 + {1'b0, v[2], 1'b0} + {2'b00, v[1]};
      v[0]     = tree[leaf_idx];
      return v;
   endfunction

   // Make every node on the path to way w point away from w.
   function automatic logic [6:0] plru_touch(input logic [6:0] tree, input logic [2:0] w);
      logic [6:0] t;
      logic [2:0] leaf_idx;
      t    = tree;
      t[0] = ~w[2];
      if (w[2]) begin
         t[2] = ~w[1];
      end else begin
         t[1] = ~w[1];
      end
      leaf_idx    = 3'd3 + {1'b0, w[2:1]};
      t[leaf_idx] = ~w[0];
      return t;
   endfunction

   // Lowest-index way whose valid bit is clear (0 when the mask is all ones).
   function automatic logic [2:0] lowest_invalid(input logic [7:0] mask);
      logic [2:0] v;
      v = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!mask[i]) begin
            v = 3'(i);
         end
      end
      return v;
   endfunction

   // Victim selection and tree update from the tree read during READ.
   always_comb begin
      w_victim   = 3'd0;
      w_new_tree = i_data_in_7;
      if (r_op) begin
         // Filling an invalid way always beats evicting a valid one.
         if (r_mask != 8'hFF) begin
            w_victim = lowest_invalid(r_mask);
         end else begin
            w_victim = plru_walk(i_data_in_7);
         end
         w_new_tree = plru_touch(i_data_in_7, w_victim);
      end else begin
         w_victim   = 3'd0;
         w_new_tree = plru_touch(i_data_in_7, r_way);
      end
   end

   // Request FSM with registered handshake, strobe and data outputs.
   always_ff @(posedge fire or negedge rstn) begin
      if (!rstn) begin
         r_state        <= ST_IDLE;
         r_op           <= 1'b0;
         r_set          <= 5'd0;
         r_way          <= 3'd0;
         r_mask         <= 8'd0;
         r_req_ready    <= 1'b1;
         r_resp_valid   <= 1'b0;
         r_write_enable <= 1'b0;
         r_victim       <= 3'd0;
         r_data_out     <= 7'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_op        <= i_req_op;
                  r_set       <= i_req_set_5;
                  r_way       <= i_req_way_3;
                  r_mask      <= i_valid_mask_8;
                  r_req_ready <= 1'b0;
                  r_state     <= ST_READ;
               end
            end
            ST_READ: begin
               r_victim       <= w_victim;
               r_data_out     <= w_new_tree;
               r_write_enable <= 1'b1;
               r_state        <= ST_WRITE;
            end
            ST_WRITE: begin
               r_write_enable <= 1'b0;
               r_resp_valid   <= 1'b1;
               r_state        <= ST_RESP;
            end
            ST_RESP: begin
               if (i_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_write_enable <= 1'b0;
               r_resp_valid   <= 1'b0;
               r_req_ready    <= 1'b1;
               r_state        <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready          = r_req_ready;
   assign o_resp_valid         = r_resp_valid;
   assign o_victim_way_3       = r_victim;
   assign o_plru_buffer_addr_5 = r_set;
   assign o_plru_write_enable  = r_write_enable;
   assign o_data_out_7         = r_data_out;

endmodule

// File: tb/tb_dcache_plru_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_plru_controller
//
// Directed bench for dcache_plru_controller. Models the PLRU tree buffer as a
// 32-entry array with combinational read and clocked write, and checks every
// step against hand-computed tree/victim values. Outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_dcache_plru_controller;

   logic       fire;
   logic       rstn;
   logic       i_req_valid;
   logic       o_req_ready;
   logic       i_req_op;
   logic [4:0] i_req_set_5;
   logic [2:0] i_req_way_3;
   logic [7:0] i_valid_mask_8;
   logic       o_resp_valid;
   logic       i_resp_ready;
   logic [2:0] o_victim_way_3;
   logic [4:0] o_plru_buffer_addr_5;
   logic       o_plru_write_enable;
   logic [6:0] o_data_out_7;
   logic [6:0] i_data_in_7;

   logic [6:0] mem [32] = '{default: 7'd0};
   int         wr_count = 0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   dcache_plru_controller dut (
      .fire                 (fire),
      .rstn                 (rstn),
      .i_req_valid          (i_req_valid),
      .o_req_ready          (o_req_ready),
      .i_req_op             (i_req_op),
      .i_req_set_5          (i_req_set_5),
      .i_req_way_3          (i_req_way_3),
      .i_valid_mask_8       (i_valid_mask_8),
      .o_resp_valid         (o_resp_valid),
      .i_resp_ready         (i_resp_ready),
      .o_victim_way_3       (o_victim_way_3),
      .o_plru_buffer_addr_5 (o_plru_buffer_addr_5),
      .o_plru_write_enable  (o_plru_write_enable),
      .o_data_out_7         (o_data_out_7),
      .i_data_in_7          (i_data_in_7)
   );

   initial fire = 1'b0;
   always #5 fire = ~fire;

   // Tree buffer model: combinational read, write on the strobe.
   assign i_data_in_7 = mem[o_plru_buffer_addr_5];

   always @(posedge fire) begin
      if (o_plru_write_enable) begin
         mem[o_plru_buffer_addr_5] <= o_data_out_7;
         wr_count                  <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full request: accept, READ, WRITE, RESP, handshake back to IDLE.
   task automatic do_req(input string name, input logic op, input logic [4:0] set,
                         input logic [2:0] way, input logic [7:0] mask,
                         input logic [2:0] exp_v, input logic [6:0] exp_t);
      int wc0;
      check({name, "_idle_ready"}, o_req_ready, 1);
      wc0            = wr_count;
      i_req_valid    = 1'b1;
      i_req_op       = op;
      i_req_set_5    = set;
      i_req_way_3    = way;
      i_valid_mask_8 = mask;
      @(posedge fire);
      #1 i_req_valid = 1'b0;
      @(negedge fire);
      check({name, "_read_ready"}, o_req_ready, 0);
      check({name, "_read_addr"}, o_plru_buffer_addr_5, set);
      check({name, "_read_we"}, o_plru_write_enable, 0);
      @(negedge fire);
      check({name, "_write_we"}, o_plru_write_enable, 1);
      check({name, "_write_data"}, o_data_out_7, exp_t);
      check({name, "_write_addr"}, o_plru_buffer_addr_5, set);
      check({name, "_write_rv"}, o_resp_valid, 0);
      @(negedge fire);
      check({name, "_resp_valid"}, o_resp_valid, 1);
      check({name, "_victim"}, o_victim_way_3, exp_v);
      check({name, "_resp_we"}, o_plru_write_enable, 0);
      check({name, "_mem"}, mem[set], exp_t);
      check({name, "_wr_once"}, wr_count, wc0 + 1);
      i_resp_ready = 1'b1;
      @(negedge fire);
      check({name, "_done_rv"}, o_resp_valid, 0);
      check({name, "_done_ready"}, o_req_ready, 1);
      i_resp_ready = 1'b0;
   endtask

   initial begin
      int wc0;
      rstn           = 1'b0;
      i_req_valid    = 1'b0;
      i_req_op       = 1'b0;
      i_req_set_5    = 5'd0;
      i_req_way_3    = 3'd0;
      i_valid_mask_8 = 8'd0;
      i_resp_ready   = 1'b0;
      repeat (3) @(negedge fire);
      check("rst_ready", o_req_ready, 1);
      check("rst_rv", o_resp_valid, 0);
      check("rst_victim", o_victim_way_3, 0);
      check("rst_addr", o_plru_buffer_addr_5, 0);
      check("rst_we", o_plru_write_enable, 0);
      check("rst_data", o_data_out_7, 0);
      rstn = 1'b1;
      @(negedge fire);

      // PLRU walk on empty tree, then on the touched tree.
      do_req("alloc3a", 1'b1, 5'd3, 3'd0, 8'hFF, 3'd0, 7'h0B);
      do_req("alloc3b", 1'b1, 5'd3, 3'd0, 8'hFF, 3'd4, 7'h2E);
      // Invalid-way priority.
      do_req("alloc9", 1'b1, 5'd9, 3'd0, 8'hF3, 3'd2, 7'h11);
      // TOUCH reports way 0 right after an ALLOC that chose way 2.
      do_req("touch31", 1'b0, 5'd31, 3'd5, 8'h00, 3'd0, 7'h04);
      // Boundaries: all invalid -> way 0; only way 7 invalid -> way 7.
      do_req("alloc5z", 1'b1, 5'd5, 3'd0, 8'h00, 3'd0, 7'h0B);
      do_req("alloc6w7", 1'b1, 5'd6, 3'd0, 8'h7F, 3'd7, 7'h00);

      // Stall in RESP with a new request pending; tree 2E -> victim 2, tree 3D.
      i_req_valid    = 1'b1;
      i_req_op       = 1'b1;
      i_req_set_5    = 5'd3;
      i_valid_mask_8 = 8'hFF;
      @(posedge fire);
      #1;
      i_req_op       = 1'b0;
      i_req_set_5    = 5'd0;
      i_req_way_3    = 3'd7;
      @(negedge fire);
      check("hold_read_addr", o_plru_buffer_addr_5, 3);
      @(negedge fire);
      check("hold_write_data", o_data_out_7, 7'h3D);
      @(negedge fire);
      wc0 = wr_count;
      for (int k = 0; k < 5; k++) begin
         check("hold_rv", o_resp_valid, 1);
         check("hold_victim", o_victim_way_3, 2);
         check("hold_ready", o_req_ready, 0);
         check("hold_no_write", wr_count, wc0);
         check("hold_addr", o_plru_buffer_addr_5, 3);
         @(negedge fire);
      end
      i_resp_ready = 1'b1;
      @(negedge fire);
      check("hold_rel_ready", o_req_ready, 1);
      check("hold_rel_rv", o_resp_valid, 0);
      i_resp_ready = 1'b0;
      // Pending TOUCH set 0 way 7 on a zero tree: writes 00 even though unchanged.
      @(posedge fire);
      #1 i_req_valid = 1'b0;
      @(negedge fire);
      check("set0_read_addr", o_plru_buffer_addr_5, 0);
      check("set0_read_ready", o_req_ready, 0);
      @(negedge fire);
      check("set0_write_we", o_plru_write_enable, 1);
      check("set0_write_data", o_data_out_7, 7'h00);
      @(negedge fire);
      check("set0_resp_rv", o_resp_valid, 1);
      check("set0_victim", o_victim_way_3, 0);
      check("set0_wr_once", wr_count, wc0 + 1);
      check("set3_mem", mem[3], 7'h3D);
      i_resp_ready = 1'b1;
      @(negedge fire);
      i_resp_ready = 1'b0;

      // Reset asserted during WRITE aborts the request.
      do_req("alloc12", 1'b1, 5'd12, 3'd0, 8'hFF, 3'd0, 7'h0B);
      i_req_valid    = 1'b1;
      i_req_op       = 1'b1;
      i_req_set_5    = 5'd10;
      i_valid_mask_8 = 8'hFF;
      @(posedge fire);
      #1 i_req_valid = 1'b0;
      @(negedge fire);
      @(negedge fire);
      check("abort_write_we", o_plru_write_enable, 1);
      check("abort_write_data", o_data_out_7, 7'h0B);
      wc0 = wr_count;
      #1 rstn = 1'b0;
      #1;
      check("abort_ready", o_req_ready, 1);
      check("abort_rv", o_resp_valid, 0);
      check("abort_victim", o_victim_way_3, 0);
      check("abort_addr", o_plru_buffer_addr_5, 0);
      check("abort_we", o_plru_write_enable, 0);
      check("abort_data", o_data_out_7, 0);
      @(posedge fire);
      #1;
      check("abort_no_write", wr_count, wc0);
      check("abort_mem", mem[10], 7'h00);
      @(negedge fire);
      rstn = 1'b1;
      @(negedge fire);
      @(negedge fire);
      check("post_ready", o_req_ready, 1);
      check("post_rv", o_resp_valid, 0);
      check("post_we", o_plru_write_enable, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
